// File: rtl/ql_kbd_pkg.sv
// Shared definitions for the QL keyboard matrix: key indices, ps2_key field
// positions and the pending-release queue entry.
package ql_kbd_pkg;

   typedef logic [5:0] key_idx_t;

   // ps2_key field positions
   localparam int unsigned PS2_TOGGLE   = 10;
   localparam int unsigned PS2_PRESSED  = 9;
   localparam int unsigned PS2_EXTENDED = 8;
   localparam int unsigned PS2_CODE_MSB = 7;
   localparam int unsigned PS2_CODE_LSB = 0;

   // QL matrix indices, bit row*8+col
   localparam key_idx_t KEY_ENTER = 6'd0;
   localparam key_idx_t KEY_F1    = 6'd1;
   localparam key_idx_t KEY_F2    = 6'd2;
   localparam key_idx_t KEY_F3    = 6'd3;
   localparam key_idx_t KEY_F4    = 6'd4;
   localparam key_idx_t KEY_F5    = 6'd5;
   localparam key_idx_t KEY_1     = 6'd6;
   localparam key_idx_t KEY_2     = 6'd7;
   localparam key_idx_t KEY_3     = 6'd8;
   localparam key_idx_t KEY_LEFT  = 6'd9;
   localparam key_idx_t KEY_UP    = 6'd10;
   localparam key_idx_t KEY_ESC   = 6'd11;
   localparam key_idx_t KEY_RIGHT = 6'd12;
   localparam key_idx_t KEY_SHIFT = 6'd13;
   localparam key_idx_t KEY_SPACE = 6'd14;
   localparam key_idx_t KEY_DOWN  = 6'd15;
   localparam key_idx_t KEY_CTRL  = 6'd16;
   localparam key_idx_t KEY_ALT   = 6'd17;
   localparam key_idx_t KEY_A     = 6'd18;
   localparam key_idx_t KEY_B     = 6'd19;
   localparam key_idx_t KEY_C     = 6'd20;
   localparam key_idx_t KEY_D     = 6'd21;
   localparam key_idx_t KEY_E     = 6'd22;
   localparam key_idx_t KEY_F     = 6'd23;
   localparam key_idx_t KEY_G     = 6'd24;
   localparam key_idx_t KEY_H     = 6'd25;
   localparam key_idx_t KEY_I     = 6'd26;
   localparam key_idx_t KEY_J     = 6'd27;
   localparam key_idx_t KEY_K     = 6'd28;
   localparam key_idx_t KEY_L     = 6'd29;
   localparam key_idx_t KEY_M     = 6'd30;
   localparam key_idx_t KEY_N     = 6'd31;
   localparam key_idx_t KEY_O     = 6'd32;
   localparam key_idx_t KEY_P     = 6'd33;
   localparam key_idx_t KEY_Q     = 6'd34;
   localparam key_idx_t KEY_R     = 6'd35;
   localparam key_idx_t KEY_S     = 6'd36;
   localparam key_idx_t KEY_T     = 6'd37;
   localparam key_idx_t KEY_U     = 6'd38;
   localparam key_idx_t KEY_V     = 6'd39;
   localparam key_idx_t KEY_W     = 6'd40;
   localparam key_idx_t KEY_X     = 6'd41;
   localparam key_idx_t KEY_Y     = 6'd42;
   localparam key_idx_t KEY_Z     = 6'd43;
   localparam key_idx_t KEY_4     = 6'd44;
   localparam key_idx_t KEY_5     = 6'd45;
   localparam key_idx_t KEY_6     = 6'd46;
   localparam key_idx_t KEY_7     = 6'd47;
   localparam key_idx_t KEY_8     = 6'd48;
   localparam key_idx_t KEY_9     = 6'd49;
   localparam key_idx_t KEY_0     = 6'd50;
   localparam key_idx_t KEY_TAB   = 6'd51;
   localparam key_idx_t KEY_COMMA = 6'd52;
   localparam key_idx_t KEY_DOT   = 6'd53;

   typedef struct packed {
      logic     valid;
      key_idx_t idx;
   } rel_entry_t;

endpackage

// File: rtl/ql_kbd_map.sv
// Combinational PS/2 set-2 scancode to QL matrix index translation.
module ql_kbd_map
   import ql_kbd_pkg::*;
(
   input  logic       extended,
   input  logic [7:0] scancode,
   output logic [5:0] idx,
   output logic       valid
);

   always_comb begin
      idx   = KEY_SPACE;
      valid = 1'b1;
      case ({extended, scancode})
         9'h05A, 9'h15A: idx = KEY_ENTER;
         9'h005:         idx = KEY_F1;
         9'h006:         idx = KEY_F2;
         9'h004:         idx = KEY_F3;
         9'h00C:         idx = KEY_F4;
         9'h003:         idx = KEY_F5;
         9'h016:         idx = KEY_1;
         9'h01E:         idx = KEY_2;
         9'h026:         idx = KEY_3;
         9'h025:         idx = KEY_4;
         9'h02E:         idx = KEY_5;
         9'h036:         idx = KEY_6;
         9'h03D:         idx = KEY_7;
         9'h03E:         idx = KEY_8;
         9'h046:         idx = KEY_9;
         9'h045:         idx = KEY_0;
         9'h16B:         idx = KEY_LEFT;
         9'h175:         idx = KEY_UP;
         9'h174:         idx = KEY_RIGHT;
         9'h172:         idx = KEY_DOWN;
         9'h076:         idx = KEY_ESC;
         9'h012, 9'h059: idx = KEY_SHIFT;
         9'h014, 9'h114: idx = KEY_CTRL;
         9'h011, 9'h111: idx = KEY_ALT;
         9'h029:         idx = KEY_SPACE;
         9'h00D:         idx = KEY_TAB;
         9'h041:         idx = KEY_COMMA;
         9'h049:         idx = KEY_DOT;
         9'h01C:         idx = KEY_A;
         9'h032:         idx = KEY_B;
         9'h021:         idx = KEY_C;
         9'h023:         idx = KEY_D;
         9'h024:         idx = KEY_E;
         9'h02B:         idx = KEY_F;
         9'h034:         idx = KEY_G;
         9'h033:         idx = KEY_H;
         9'h043:         idx = KEY_I;
         9'h03B:         idx = KEY_J;
         9'h042:         idx = KEY_K;
         9'h04B:         idx = KEY_L;
         9'h03A:         idx = KEY_M;
         9'h031:         idx = KEY_N;
         9'h044:         idx = KEY_O;
         9'h04D:         idx = KEY_P;
         9'h015:         idx = KEY_Q;
         9'h02D:         idx = KEY_R;
         9'h01B:         idx = KEY_S;
         9'h02C:         idx = KEY_T;
         9'h03C:         idx = KEY_U;
         9'h02A:         idx = KEY_V;
         9'h01D:         idx = KEY_W;
         9'h022:         idx = KEY_X;
         9'h035:         idx = KEY_Y;
         9'h01A:         idx = KEY_Z;
         default:        valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/ql_kbd_matrix.sv
// PS/2 key events to QL keyboard matrix with delayed key release.
// Optional joystick overlay compiled in with QL_KBD_JOYSTICK_EN.
module ql_kbd_matrix
   import ql_kbd_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 220000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk11,
   input  logic        reset,
   input  logic [64:0] ps2_key,
   input  logic [4:0]  js0,
   input  logic [4:0]  js1,
   output logic [63:0] matrix
);

   localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FIFO_DEPTH);

   logic [10:0]        ps2_q;
   logic               toggle_q;
   logic [63:0]        key_q, key_d;
   logic [63:0]        matrix_q, joy_ov;
   rel_entry_t         fifo_q [FIFO_DEPTH];
   rel_entry_t         fifo_d [FIFO_DEPTH];
   rel_entry_t         head;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [5:0]         map_idx;
   logic               map_valid;
   logic               key_event, press_ev, rel_ev, dup, fifo_empty, fifo_full;
   logic               expire, push, pop;

   logic unused_ps2;
   assign unused_ps2 = ^ps2_key[64:11];

   ql_kbd_map u_map (
      .extended (ps2_q[PS2_EXTENDED]),
      .scancode (ps2_q[PS2_CODE_MSB:PS2_CODE_LSB]),
      .idx      (map_idx),
      .valid    (map_valid)
   );

   assign key_event  = (ps2_q[PS2_TOGGLE] != toggle_q) && map_valid;
   assign press_ev   = key_event && ps2_q[PS2_PRESSED];
   assign rel_ev     = key_event && !ps2_q[PS2_PRESSED];
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CNT_FULL);
   assign head       = fifo_q[rd_ptr_q];
   assign expire     = !fifo_empty && (timer_q == TIMER_LAST);

   // Popped slots get their valid bit cleared, so valid implies occupied.
   always_comb begin
      dup = 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (fifo_q[i].valid && (fifo_q[i].idx == map_idx)) dup = 1'b1;
      end
   end

   assign push = rel_ev && !dup;
   assign pop  = expire || (push && fifo_full);

   always_comb begin
      key_d    = key_q;
      fifo_d   = fifo_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      timer_d  = timer_q;
      if (!fifo_empty) timer_d = timer_q + 1'b1;
      if (pop) begin
         if (head.valid) key_d[head.idx] = 1'b0;
         fifo_d[rd_ptr_q].valid = 1'b0;
         rd_ptr_d = rd_ptr_q + 1'b1;
         timer_d  = '0;
      end
      if (push) begin
         fifo_d[wr_ptr_q] = '{valid: 1'b1, idx: map_idx};
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (fifo_empty) timer_d = '0;
      end
      // Press comes last so it wins over a same-cycle pop of the same key.
      if (press_ev) begin
         key_d[map_idx] = 1'b1;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_q[i].idx == map_idx) fifo_d[i].valid = 1'b0;
         end
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

`ifdef QL_KBD_JOYSTICK_EN
   always_comb begin
      joy_ov            = '0;
      joy_ov[KEY_SPACE] = js0[4];
      joy_ov[KEY_UP]    = js0[3];
      joy_ov[KEY_DOWN]  = js0[2];
      joy_ov[KEY_LEFT]  = js0[1];
      joy_ov[KEY_RIGHT] = js0[0];
      joy_ov[KEY_F1]    = js1[4];
      joy_ov[KEY_F2]    = js1[3];
      joy_ov[KEY_F3]    = js1[2];
      joy_ov[KEY_F4]    = js1[1];
      joy_ov[KEY_F5]    = js1[0];
   end
`else
   logic unused_js;
   assign unused_js = ^{js0, js1};
   assign joy_ov    = '0;
`endif

   // Loading the toggle history during reset keeps release of reset event-free.
   always_ff @(posedge clk11) begin
      ps2_q <= ps2_key[10:0];
      if (reset) begin
         toggle_q <= ps2_key[PS2_TOGGLE];
         key_q    <= '0;
         matrix_q <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         toggle_q <= ps2_q[PS2_TOGGLE];
         key_q    <= key_d;
         matrix_q <= key_d | joy_ov;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      end
   end

   assign matrix = matrix_q;

endmodule

// File: tb/tb_ql_kbd_matrix.sv
// Bench for ql_kbd_matrix: directed scenarios then random events against a
// deadline-based release model.
module tb_ql_kbd_matrix;

   localparam int unsigned HOLD  = 16;
   localparam int unsigned DEPTH = 4;

   logic        clk11 = 1'b0;
   logic        reset;
   logic [64:0] ps2_key;
   logic [4:0]  js0, js1;
   logic [63:0] matrix;

   ql_kbd_matrix #(
      .HOLD_CYCLES (HOLD),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk11   (clk11),
      .reset   (reset),
      .ps2_key (ps2_key),
      .js0     (js0),
      .js1     (js1),
      .matrix  (matrix)
   );

   always #5 clk11 = ~clk11;

   typedef struct {
      int idx;
      bit live;
   } pend_t;

   pend_t     pq[$];
   bit [63:0] keys;
   longint    edge_n;
   longint    deadline;
   int        n_vec;
   int        n_bad;
   bit        tog;
   bit        d1_v, d1_pr, d2_v, d2_pr;
   int        d1_idx, d2_idx;

   localparam logic [8:0] SC_A  = 9'h01C;
   localparam logic [8:0] SC_B  = 9'h032;
   localparam logic [8:0] SC_Q  = 9'h015;
   localparam logic [8:0] SC_Z  = 9'h01A;
   localparam logic [8:0] SC_SP = 9'h029;

   logic [8:0] codes [14] = '{9'h01C, 9'h032, 9'h015, 9'h01A, 9'h029, 9'h05A, 9'h016,
                              9'h005, 9'h175, 9'h16B, 9'h174, 9'h000, 9'h07E, 9'h11C};

   function automatic int ref_index(input logic [8:0] kc);
      case (kc)
         9'h01C:  return 18;
         9'h032:  return 19;
         9'h015:  return 34;
         9'h01A:  return 43;
         9'h029:  return 14;
         9'h05A:  return 0;
         9'h016:  return 6;
         9'h005:  return 1;
         9'h175:  return 10;
         9'h16B:  return 9;
         9'h174:  return 12;
         default: return -1;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, got, exp);
      end
   endtask

   // One edge of the reference: fixed release deadlines, restarted on each pop.
   task automatic model_edge(input bit v, input bit pr, input int idx);
      bit    expired, dup, push, pop, was_empty;
      pend_t h;
      expired   = (pq.size() > 0) && (edge_n == deadline);
      dup       = 1'b0;
      if (v && !pr) foreach (pq[i]) if (pq[i].live && pq[i].idx == idx) dup = 1'b1;
      push      = v && !pr && !dup;
      pop       = expired || (push && pq.size() == int'(DEPTH));
      was_empty = (pq.size() == 0);
      if (pop) begin
         h = pq.pop_front();
         if (h.live) keys[h.idx] = 1'b0;
      end
      if (push) pq.push_back('{idx: idx, live: 1'b1});
      if (pop || (push && was_empty)) deadline = edge_n + longint'(HOLD);
      if (v && pr) begin
         keys[idx] = 1'b1;
         foreach (pq[i]) if (pq[i].idx == idx) pq[i].live = 1'b0;
      end
   endtask

   task automatic tick(input bit ev, input bit pr, input logic [8:0] kc, input bit rst_in,
                       input logic [4:0] j0, input logic [4:0] j1);
      logic [63:0] exp_m;
      @(negedge clk11);
      edge_n++;
      if (reset) begin
         pq.delete();
         keys = '0;
         d1_v = 1'b0;
         d2_v = 1'b0;
      end else begin
         model_edge(d2_v, d2_pr, d2_idx);
      end
      exp_m = keys;
`ifdef QL_KBD_JOYSTICK_EN
      if (!reset) begin
         exp_m[14] |= js0[4]; exp_m[10] |= js0[3]; exp_m[15] |= js0[2];
         exp_m[9]  |= js0[1]; exp_m[12] |= js0[0];
         exp_m[1]  |= js1[4]; exp_m[2]  |= js1[3]; exp_m[3]  |= js1[2];
         exp_m[4]  |= js1[1]; exp_m[5]  |= js1[0];
      end
`endif
      check_val("matrix", matrix, exp_m);
      d2_v   = d1_v;
      d2_pr  = d1_pr;
      d2_idx = d1_idx;
      reset  = rst_in;
      ps2_key[42:11] = $urandom;
      ps2_key[64:43] = 22'($urandom);
      if (ev) begin
         tog          = ~tog;
         ps2_key[10]  = tog;
         ps2_key[9]   = pr;
         ps2_key[8:0] = kc;
      end
      d1_idx = ref_index(kc);
      d1_v   = ev && (d1_idx >= 0);
      d1_pr  = pr;
      js0    = j0;
      js1    = j1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 9'h000, 1'b0, 5'd0, 5'd0);
   endtask

   task automatic key(input bit pr, input logic [8:0] kc);
      tick(1'b1, pr, kc, 1'b0, 5'd0, 5'd0);
   endtask

   int         r;
   bit         rev, rpr, rrs;
   logic [8:0] rkc;

   initial begin
      reset    = 1'b1;
      ps2_key  = '0;
      js0      = '0;
      js1      = '0;
      tog      = 1'b0;
      edge_n   = 0;
      deadline = 0;
      n_vec    = 0;
      n_bad    = 0;
      keys     = '0;
      d1_v = 1'b0; d2_v = 1'b0; d1_pr = 1'b0; d2_pr = 1'b0; d1_idx = 0; d2_idx = 0;

      repeat (3) tick(1'b0, 1'b0, 9'h000, 1'b1, 5'd0, 5'd0);
      idle(1);
      check_val("reset_clear", matrix, 64'h0);
      idle(3);

      // press A: visible exactly two edges later; release held HOLD cycles after push
      key(1'b1, SC_A);
      idle(1);
      check_val("a_not_yet", matrix[18], 1'b0);
      idle(1);
      check_val("a_set_2cyc", matrix[18], 1'b1);
      idle(2);
      key(1'b0, SC_A);
      idle(17);
      check_val("a_held_last", matrix[18], 1'b1);
      idle(1);
      check_val("a_released", matrix[18], 1'b0);
      idle(3);

      // re-press during the release delay keeps the key down
      key(1'b1, SC_A);
      idle(3);
      key(1'b0, SC_A);
      idle(9);
      key(1'b1, SC_A);
      idle(8);
      check_val("a_repress_expiry", matrix[18], 1'b1);
      idle(30);
      check_val("a_repress_later", matrix[18], 1'b1);

      // five consecutive releases overflow a four-deep queue
      key(1'b1, SC_A); key(1'b1, SC_B); key(1'b1, SC_Q); key(1'b1, SC_Z); key(1'b1, SC_SP);
      idle(3);
      key(1'b0, SC_A); key(1'b0, SC_B); key(1'b0, SC_Q); key(1'b0, SC_Z); key(1'b0, SC_SP);
      idle(2);
      check_val("ovf_a_clear", matrix[18], 1'b0);
      check_val("ovf_b_held", matrix[19], 1'b1);
      idle(15);
      check_val("ovf_b_last", matrix[19], 1'b1);
      idle(1);
      check_val("ovf_b_clear", matrix[19], 1'b0);
      check_val("ovf_q_held", matrix[34], 1'b1);
      idle(16);
      check_val("ovf_q_clear", matrix[34], 1'b0);
      idle(40);
      check_val("ovf_all_clear", matrix, 64'h0);

      // unmapped codes change nothing; queue is empty afterwards
      key(1'b1, 9'h000);
      key(1'b1, 9'h11C);
      key(1'b0, 9'h000);
      idle(3);
      check_val("unmapped", matrix, 64'h0);
      key(1'b1, SC_B);
      idle(3);
      key(1'b0, SC_B);
      idle(17);
      check_val("b_fresh_timer", matrix[19], 1'b1);
      idle(1);
      check_val("b_fresh_clear", matrix[19], 1'b0);

      // reset with pending releases and toggle high
      key(1'b1, SC_A); key(1'b1, SC_Q);
      idle(3);
      key(1'b0, SC_A); key(1'b0, SC_Q);
      idle(4);
      tick(!tog, 1'b1, SC_Z, 1'b1, 5'd0, 5'd0);
      tick(1'b0, 1'b0, 9'h000, 1'b1, 5'd0, 5'd0);
      tick(1'b0, 1'b0, 9'h000, 1'b1, 5'd0, 5'd0);
      idle(1);
      check_val("rst_mid_clear", matrix, 64'h0);
      idle(40);
      check_val("rst_no_late", matrix, 64'h0);

`ifdef QL_KBD_JOYSTICK_EN
      tick(1'b0, 1'b0, 9'h000, 1'b0, 5'b10001, 5'd0);
      tick(1'b0, 1'b0, 9'h000, 1'b0, 5'b10001, 5'd0);
      check_val("js_fire", matrix[14], 1'b1);
      check_val("js_right", matrix[12], 1'b1);
      tick(1'b0, 1'b0, 9'h000, 1'b0, 5'd0, 5'd0);
      idle(1);
      check_val("js_off", matrix, 64'h0);
`endif

      for (int n = 0; n < 3000; n++) begin
         r   = $urandom_range(0, 99);
         rev = (r < 35);
         rpr = 1'($urandom_range(0, 1));
         rkc = codes[$urandom_range(0, 13)];
         rrs = ($urandom_range(0, 399) == 0);
         tick(rev, rpr, rkc, rrs, 5'($urandom), 5'($urandom));
      end
      idle(100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ql_kbd_matrix.md
QL_KBD_MATRIX -- requirements
Module: ql_kbd_matrix

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 220000, release delay in clk11 cycles (~20 ms).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, pending-release queue depth (power of two, >=2).
REQ-003 SHALL have port clk11  input  1  single clock; the block uses one clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ps2_key  input  65  key event: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode; [64:11] ignored.
REQ-006 SHALL have port js0  input  5  joystick 0 {fire,up,down,left,right}, active-high.
REQ-007 SHALL have port js1  input  5  joystick 1, same order.
REQ-008 SHALL have port matrix  output  64  QL key matrix, bit row*8+col, 1 = pressed, registered.

Function
REQ-009 SHALL register ps2_key once and detect an event when registered bit [10] differs from the stored previous toggle.
REQ-010 SHALL translate {extended, scancode} to a 6-bit matrix index plus valid flag through ql_kbd_map; invalid codes are dropped with no state change.
REQ-011 SHALL, on a valid press event, set the key bit in the next cycle: 2 clk11 cycles after the toggle change appears on ps2_key.
REQ-012 SHALL, on a valid press event, invalidate every pending-release entry with the same index.
REQ-013 SHALL, on a valid release event, push the index into the release FIFO and leave the bit set.
REQ-014 SHALL run a head timer, cleared on every push into an empty FIFO and on every pop, and counting while the FIFO is non-empty.
REQ-015 SHALL pop the head when the timer reaches HOLD_CYCLES-1; a valid entry clears its bit in that cycle, an invalidated entry is discarded.
REQ-016 SHALL, on release while the FIFO is full, pop the head, apply it as in REQ-015, and push the new entry in the same cycle.
REQ-017 SHALL, on release of an index already pending and valid in the FIFO, ignore the duplicate.
REQ-018 SHALL give press priority when a press of index N and a head pop of index N occur in the same cycle: bit N stays set.
REQ-019 SHALL use a head-timer width that holds HOLD_CYCLES-1 without wrap; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-020 SHALL drive matrix as key state OR the joystick overlay of REQ-026.

Reset
REQ-021 SHALL clear matrix to 64'h0 while reset is high.
REQ-022 SHALL empty the FIFO and clear the head timer while reset is high.
REQ-023 SHALL load the previous-toggle register from ps2_key[10] while reset is high, so no event fires on reset release.
REQ-024 SHALL abandon pending releases on reset asserted mid-delay; no later bit clear occurs for them.

Configuration
REQ-025 SHALL compile the joystick overlay only when macro QL_KBD_JOYSTICK_EN is defined.
REQ-026 SHALL, with the macro defined, OR registered js0 onto {SPACE=14,UP=10,DOWN=15,LEFT=9,RIGHT=12} and js1 onto {F1=1,F2=2,F3=3,F4=4,F5=5}, with 1-cycle latency and no release delay.
REQ-027 SHALL, without the macro, leave js0/js1 unused, with matrix equal to key state only.

Structure
REQ-028 SHALL place the matrix index constants (KEY_SPACE, KEY_UP, ...), the index type, and the ps2_key field positions in shared package ql_kbd_pkg.
REQ-029 SHALL implement the scancode-to-index table in a combinational sub-module ql_kbd_map; the FIFO and timer stay in ql_kbd_matrix.

Verification
REQ-030 SHALL cover: press 'A' (0x1C, toggle flip) -> its bit set exactly 2 cycles later; release -> bit still 1 at HOLD_CYCLES-1 after push, 0 one cycle after that.
REQ-031 SHALL cover: release 'A', then press 'A' 100 cycles later -> bit never drops; the entry is discarded at timer expiry.
REQ-032 SHALL cover: with HOLD_CYCLES=16 and FIFO_DEPTH=4, five releases on consecutive event cycles -> the first key clears at the fifth push, and the remaining keys clear 16 cycles apart.
REQ-033 SHALL cover: unmapped scancode 0x00 with toggle flip -> matrix unchanged and FIFO empty.
REQ-034 SHALL cover: reset asserted with 2 pending releases and ps2_key[10]=1 -> matrix 0 after reset, no spurious event after deassertion, and no late clears.
REQ-035 SHALL cover, with QL_KBD_JOYSTICK_EN: js0=5'b10001 -> matrix bits 14 and 12 set next cycle; js0=0 -> bits clear next cycle.
